mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between an
// instruction-fetch requester (I) and a data requester (D). D wins contention
// unless D also took the previous grant, which keeps fetch from starving.
// Optional build macro MEM_ARB_STATS_EN adds grant/wait statistic counters.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_i_grants,
  output logic [15:0]          stat_d_grants,
  output logic [15:0]          stat_i_wait
`endif
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 grant_d;

  // State register; an access cut short by reset is simply dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWNER_I;
      last_q    <= OWNER_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Arbitration in IDLE, latency countdown in ACCESS, one-cycle ready in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // D wins unless both are asking and D had the previous grant.
    grant_d   = d_req && !(i_req && (last_q == OWNER_D));
    case (state_q)
      S_IDLE: begin
        if (d_req || i_req) begin
          owner_d = grant_d ? OWNER_D : OWNER_I;
          last_d  = grant_d ? OWNER_D : OWNER_I;
          addr_d  = grant_d ? d_addr : i_addr;
          we_d    = grant_d && d_we;
          wdata_d = grant_d ? d_wdata : '0;
          cnt_d   = CW'(MEM_LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!we_q) begin
            if (owner_q == OWNER_D) d_rdata_d = mem_rdata;
            else                    i_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  wire in_access = (state_q == S_ACCESS);
  wire in_done   = (state_q == S_DONE);

  assign i_ready   = in_done && (owner_q == OWNER_I);
  assign d_ready   = in_done && (owner_q == OWNER_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_read  = in_access && !we_q;
  assign mem_write = in_access && we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  assign busy      = (state_q != S_IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_i_grants_q, stat_d_grants_q, stat_i_wait_q;
  wire         granting = (state_q == S_IDLE) && (d_req || i_req);

  // Free-running 16-bit counters; natural wrap at 16'hFFFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_i_grants_q <= '0;
      stat_d_grants_q <= '0;
      stat_i_wait_q   <= '0;
    end else begin
      if (granting && grant_d)  stat_d_grants_q <= stat_d_grants_q + 16'd1;
      if (granting && !grant_d) stat_i_grants_q <= stat_i_grants_q + 16'd1;
      if (i_req && (owner_q == OWNER_D) && (in_access || in_done))
        stat_i_wait_q <= stat_i_wait_q + 16'd1;
    end
  end

  assign stat_i_grants = stat_i_grants_q;
  assign stat_d_grants = stat_d_grants_q;
  assign stat_i_wait   = stat_i_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected ready events
// and memory bursts into queues, negedge monitors pop and compare.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    logic [15:0] ir;
    logic [15:0] dr;
    int          gap;
  } rexp_t;

  typedef struct {
    bit          we;
    logic [15:0] a;
    logic [15:0] wd;
  } mexp_t;

  logic clk;
  logic rst_n;

  // Instance 0: MEM_LATENCY = 2
  logic        i_req0 = 1'b0, d_req0 = 1'b0, d_we0 = 1'b0;
  logic [15:0] i_addr0 = '0, d_addr0 = '0, d_wdata0 = '0;
  logic        i_ready0, d_ready0, mem_read0, mem_write0, busy0;
  logic [15:0] i_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;

  // Instance 1: MEM_LATENCY = 1, fetch side only
  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [15:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic        i_ready1, d_ready1, mem_read1, mem_write1, busy1;
  logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] s_ig0, s_dg0, s_iw0, s_ig1, s_dg1, s_iw1;
`endif

  logic [15:0] mem [256];
  rexp_t rq[$];
  rexp_t rq1[$];
  mexp_t mq[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  assign mem_rdata0 = mem_read0 ? mem[mem_addr0[7:0]] : 16'h0000;
  assign mem_rdata1 = mem_read1 ? mem[mem_addr1[7:0]] : 16'h0000;

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut0 (
    .clk(clk), .reset_n(rst_n),
    .i_req(i_req0), .i_addr(i_addr0), .i_ready(i_ready0), .i_rdata(i_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ready(d_ready0), .d_rdata(d_rdata0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_grants(s_ig0), .stat_d_grants(s_dg0), .stat_i_wait(s_iw0)
`endif
  );

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(rst_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_grants(s_ig1), .stat_d_grants(s_dg1), .stat_i_wait(s_iw1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Ready monitor, instance 0
  int last_rdy0 = 0;
  always @(negedge clk) begin
    rexp_t e;
    if (rst_n && (i_ready0 || d_ready0)) begin
      if (rq.size() == 0) flag("ready0_unexpected");
      else begin
        e = rq.pop_front();
        chk("ready0_owner", {30'b0, i_ready0, d_ready0}, e.is_d ? 32'd1 : 32'd2);
        chk("i_rdata0", 32'(i_rdata0), 32'(e.ir));
        chk("d_rdata0", 32'(d_rdata0), 32'(e.dr));
        if (e.gap != 0) chk("ready0_gap", cyc - last_rdy0, e.gap);
        $display("ready0 %s ir=%h dr=%h cycle %0d", e.is_d ? "D" : "I", i_rdata0, d_rdata0, cyc);
      end
      last_rdy0 = cyc;
    end
  end

  // Ready monitor, instance 1
  int last_rdy1 = 0;
  always @(negedge clk) begin
    rexp_t e;
    if (rst_n && (i_ready1 || d_ready1)) begin
      if (rq1.size() == 0) flag("ready1_unexpected");
      else begin
        e = rq1.pop_front();
        chk("ready1_owner", {30'b0, i_ready1, d_ready1}, e.is_d ? 32'd1 : 32'd2);
        chk("i_rdata1", 32'(i_rdata1), 32'(e.ir));
        if (e.gap != 0) chk("ready1_gap", cyc - last_rdy1, e.gap);
        $display("ready1 I ir=%h cycle %0d", i_rdata1, cyc);
      end
      last_rdy1 = cyc;
    end
  end

  // Memory-burst monitor, instance 0
  bit m_prev = 1'b0;
  int m_len = 0;
  always @(negedge clk) begin
    mexp_t m;
    logic  strobe;
    strobe = mem_read0 | mem_write0;
    if (!rst_n) begin
      m_prev = 1'b0;
      m_len  = 0;
    end else begin
      if (mem_read0 && mem_write0) flag("strobe_both");
      if (strobe && !m_prev) begin
        m_len = 1;
        if (mq.size() == 0) flag("mem_unexpected");
        else begin
          m = mq.pop_front();
          chk("mem_write", 32'(mem_write0), 32'(m.we));
          chk("mem_addr", 32'(mem_addr0), 32'(m.a));
          if (m.we) chk("mem_wdata", 32'(mem_wdata0), 32'(m.wd));
        end
      end else if (strobe) begin
        m_len++;
      end else begin
        if (m_prev) chk("burst_len", m_len, 2);
        chk("idle_mem_addr", 32'(mem_addr0), 32'd0);
        chk("idle_mem_wdata", 32'(mem_wdata0), 32'd0);
      end
      m_prev = strobe;
    end
  end

  task automatic drive_i(input logic [15:0] a, input bit hold, output int n);
    i_req0 = 1'b1;
    i_addr0 = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ready0 && n < 30);
    if (!i_ready0) flag("i0_timeout");
    @(posedge clk); #1;
    if (!hold) i_req0 = 1'b0;
  endtask

  task automatic drive_d(input bit we, input logic [15:0] a, input logic [15:0] wd,
                         input bit hold, output int n);
    d_req0 = 1'b1;
    d_we0 = we;
    d_addr0 = a;
    d_wdata0 = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ready0 && n < 30);
    if (!d_ready0) flag("d0_timeout");
    @(posedge clk); #1;
    if (!hold) d_req0 = 1'b0;
  endtask

  task automatic drive_i1(input logic [15:0] a, input bit hold, output int n);
    i_req1 = 1'b1;
    i_addr1 = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ready1 && n < 30);
    if (!i_ready1) flag("i1_timeout");
    @(posedge clk); #1;
    if (!hold) i_req1 = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd1, nd2, ni1, ni2;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000 | 16'(i);
    mem[8'h03] = 16'h7777; mem[8'h04] = 16'h4444; mem[8'h05] = 16'h5555;
    mem[8'h10] = 16'hA123; mem[8'h11] = 16'h1111; mem[8'h12] = 16'h2222;
    mem[8'h13] = 16'h3333; mem[8'h20] = 16'hBEEF; mem[8'h21] = 16'hCAFE;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", {30'b0, i_ready0, d_ready0}, 32'd0);
    chk("rst_strobes", {30'b0, mem_read0, mem_write0}, 32'd0);
    chk("rst_rdata", {i_rdata0, d_rdata0}, 32'd0);

    // 1: I read of 0x0010
    @(posedge clk); #1;
    rq.push_back('{is_d: 1'b0, ir: 16'hA123, dr: 16'h0000, gap: 0});
    mq.push_back('{we: 1'b0, a: 16'h0010, wd: 16'h0000});
    drive_i(16'h0010, 1'b0, n);
    chk("t1_latency", n, 4);

    // 2: D write of 0x5A5A to 0x0040, d_rdata stays 0
    rq.push_back('{is_d: 1'b1, ir: 16'hA123, dr: 16'h0000, gap: 0});
    mq.push_back('{we: 1'b1, a: 16'h0040, wd: 16'h5A5A});
    drive_d(1'b1, 16'h0040, 16'h5A5A, 1'b0, n);
    chk("t2_latency", n, 4);

    // 4: reset during the first ACCESS cycle of a D read
    @(posedge clk); #1;
    d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 16'h0020;
    @(posedge clk); #1;
    chk("t4_pre_busy", 32'(busy0), 32'd1);
    chk("t4_pre_read", 32'(mem_read0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy0), 32'd0);
    chk("t4_strobes", {30'b0, mem_read0, mem_write0}, 32'd0);
    chk("t4_mem_addr", 32'(mem_addr0), 32'd0);
    chk("t4_rdata", {i_rdata0, d_rdata0}, 32'd0);
    d_req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_idle_busy", 32'(busy0), 32'd0);
    end

    // 3: contention from reset, grant order D,I,D,I, readies 4 cycles apart
    rq.push_back('{is_d: 1'b1, ir: 16'h0000, dr: 16'hBEEF, gap: 0});
    rq.push_back('{is_d: 1'b0, ir: 16'h1111, dr: 16'hBEEF, gap: 4});
    rq.push_back('{is_d: 1'b1, ir: 16'h1111, dr: 16'hCAFE, gap: 4});
    rq.push_back('{is_d: 1'b0, ir: 16'h2222, dr: 16'hCAFE, gap: 4});
    mq.push_back('{we: 1'b0, a: 16'h0020, wd: 16'h0000});
    mq.push_back('{we: 1'b0, a: 16'h0011, wd: 16'h0000});
    mq.push_back('{we: 1'b0, a: 16'h0021, wd: 16'h0000});
    mq.push_back('{we: 1'b0, a: 16'h0012, wd: 16'h0000});
    @(posedge clk); #1;
    fork
      begin
        drive_d(1'b0, 16'h0020, 16'h0000, 1'b1, nd1);
        drive_d(1'b0, 16'h0021, 16'h0000, 1'b0, nd2);
      end
      begin
        drive_i(16'h0011, 1'b1, ni1);
        drive_i(16'h0012, 1'b0, ni2);
      end
    join
`ifdef MEM_ARB_STATS_EN
    chk("stat_d_grants", 32'(s_dg0), 32'd2);
    chk("stat_i_grants", 32'(s_ig0), 32'd2);
    chk("stat_i_wait", 32'(s_iw0), 32'd6);
`endif

    // 6: i_req held through DONE, second fetch starts from IDLE
    rq.push_back('{is_d: 1'b0, ir: 16'h3333, dr: 16'hCAFE, gap: 0});
    rq.push_back('{is_d: 1'b0, ir: 16'h3333, dr: 16'hCAFE, gap: 4});
    mq.push_back('{we: 1'b0, a: 16'h0013, wd: 16'h0000});
    mq.push_back('{we: 1'b0, a: 16'h0013, wd: 16'h0000});
    drive_i(16'h0013, 1'b1, n);
    drive_i(16'h0013, 1'b0, n);

    // 5: MEM_LATENCY=1 instance, back-to-back fetches every 3 cycles
    rq1.push_back('{is_d: 1'b0, ir: 16'h7777, dr: 16'h0000, gap: 0});
    rq1.push_back('{is_d: 1'b0, ir: 16'h4444, dr: 16'h0000, gap: 3});
    rq1.push_back('{is_d: 1'b0, ir: 16'h5555, dr: 16'h0000, gap: 3});
    drive_i1(16'h0003, 1'b1, n);
    chk("t5_latency", n, 3);
    drive_i1(16'h0004, 1'b1, n);
    drive_i1(16'h0005, 1'b0, n);

    repeat (4) @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("rq1_drained", rq1.size(), 0);
    chk("mq_drained", mq.size(), 0);
    chk("end_busy", {30'b0, busy0, busy1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
